// File: rtl/pipelining_pkg.sv
// ---------------------------------------------------------------------------
// pipelining_pkg
// Purpose : shared width helpers for the pipelining blocks. The count width
//           must hold the values 0..DEPTH inclusive; the pointer width must
//           address DEPTH entries.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package pipelining_pkg;

  // Bits needed for an occupancy count ranging 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed for a pointer ranging 0..depth-1, never narrower than 1.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ring_pointer.sv
// ---------------------------------------------------------------------------
// ring_pointer
// Purpose : wrapping index for a ring of DEPTH entries (DEPTH need not be a
//           power of two).
// Ports   : clk_i  - clock
//           rst_i  - asynchronous active-high reset, zeroes the pointer
//           incr   - advance by one, wrapping DEPTH-1 -> 0
//           clr    - synchronous clear to 0, wins over incr
//           ptr    - current pointer value
// ---------------------------------------------------------------------------
module ring_pointer
  import pipelining_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             incr,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  // Explicit wrap compare so non power-of-two depths work.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (incr) begin
      if (ptr == PTR_W'(DEPTH - 1)) ptr <= '0;
      else                          ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_buffer.sv
// ---------------------------------------------------------------------------
// pipeline_buffer
// Purpose : DEPTH-entry FIFO ring between a valid/ready producer and a
//           valid/ready consumer, with external stall and flush controls.
// Ports   : clk_i, rst_i (async active-high)
//           s_data_data/valid/ready  - producer side
//           m_data_data/valid/ready  - consumer side (data is zero when !valid)
//           s_ctrl_stall             - freezes both handshakes and all state
//           s_ctrl_flush             - blocks handshakes, empties the ring
//           s_status_busy/full/count - occupancy status
// Config  : PIPELINE_BUFFER_FALLTHROUGH_EN - when defined, an empty buffer
//           passes s_data_* straight to m_data_* with zero latency; when not
//           defined, output is registered with exactly one cycle of latency.
// ---------------------------------------------------------------------------
module pipeline_buffer
  import pipelining_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        s_data_data,
  input  logic                         s_data_valid,
  output logic                         s_data_ready,
  output logic [DATA_WIDTH-1:0]        m_data_data,
  output logic                         m_data_valid,
  input  logic                         m_data_ready,
  input  logic                         s_ctrl_stall,
  input  logic                         s_ctrl_flush,
  output logic                         s_status_busy,
  output logic                         s_status_full,
  output logic [$clog2(DEPTH+1)-1:0]   s_status_count
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic                  open_gate;
  logic                  push;
  logic                  pop;
  logic                  store_push;
  logic                  store_pop;

  // Handshake gating. Reset is folded in so that outputs are quiet for the
  // whole time rst_i is high, not just after the first edge.
  always_comb begin
    open_gate    = ~rst_i & ~s_ctrl_stall & ~s_ctrl_flush;
    empty        = (count == '0);
    full         = (count == CNT_W'(DEPTH));
    s_data_ready = open_gate & ~full;
`ifdef PIPELINE_BUFFER_FALLTHROUGH_EN
    m_data_valid = open_gate & (~empty | s_data_valid);
    rd_data      = empty ? s_data_data : mem[rd_ptr];
`else
    m_data_valid = open_gate & ~empty;
    rd_data      = mem[rd_ptr];
`endif
    m_data_data  = m_data_valid ? rd_data : '0;
    push         = s_data_valid & s_data_ready;
    pop          = m_data_valid & m_data_ready;
`ifdef PIPELINE_BUFFER_FALLTHROUGH_EN
    // A bypassed payload never touches storage; a payload offered while
    // empty but not taken is stored as usual.
    store_push   = push & ~(empty & m_data_ready);
    store_pop    = pop & ~empty;
`else
    store_push   = push;
    store_pop    = pop;
`endif
  end

  ring_pointer #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .incr  (store_push),
    .clr   (s_ctrl_flush),
    .ptr   (wr_ptr)
  );

  ring_pointer #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .incr  (store_pop),
    .clr   (s_ctrl_flush),
    .ptr   (rd_ptr)
  );

  // Occupancy: simultaneous push and pop cancel out. Handshake gating makes
  // overflow and underflow impossible, so no saturation is needed here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (s_ctrl_flush) begin
      count <= '0;
    end else begin
      case ({store_push, store_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared by reset so no stale payload survives it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (store_push) begin
      mem[wr_ptr] <= s_data_data;
    end
  end

  assign s_status_busy  = ~empty;
  assign s_status_full  = full;
  assign s_status_count = count;

endmodule

// File: tb/tb_pipeline_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_buffer
// Purpose : directed bench for pipeline_buffer. Two instances share clock and
//           reset: u_dut4 (DEPTH=4) and u_dut3 (DEPTH=3). Each cycle the bench
//           predicts handshakes and status from its own queue of stored
//           payloads and compares against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_buffer;

`ifdef PIPELINE_BUFFER_FALLTHROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic        clk;
  logic        rst;

  logic [31:0] s_dat4, m_dat4, s_dat3, m_dat3;
  logic        s_val4, s_rdy4, m_val4, m_rdy4, stall4, flush4, busy4, full4;
  logic        s_val3, s_rdy3, m_val3, m_rdy3, stall3, flush3, busy3, full3;
  logic [2:0]  cnt4;
  logic [1:0]  cnt3;

  logic [31:0] sb4[$];
  logic [31:0] sb3[$];

  int checks = 0;
  int errors = 0;

  pipeline_buffer #(.DATA_WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_data_data    (s_dat4),
    .s_data_valid   (s_val4),
    .s_data_ready   (s_rdy4),
    .m_data_data    (m_dat4),
    .m_data_valid   (m_val4),
    .m_data_ready   (m_rdy4),
    .s_ctrl_stall   (stall4),
    .s_ctrl_flush   (flush4),
    .s_status_busy  (busy4),
    .s_status_full  (full4),
    .s_status_count (cnt4)
  );

  pipeline_buffer #(.DATA_WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_data_data    (s_dat3),
    .s_data_valid   (s_val3),
    .s_data_ready   (s_rdy3),
    .m_data_data    (m_dat3),
    .m_data_valid   (m_val3),
    .m_data_ready   (m_rdy3),
    .s_ctrl_stall   (stall3),
    .s_ctrl_flush   (flush3),
    .s_status_busy  (busy3),
    .s_status_full  (full3),
    .s_status_count (cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted, and reported with tag/observed/expected on error.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one instance for a cycle; the other instance is held idle.
  task automatic applyStimulus(input int u, input logic sv, input logic [31:0] sd,
                               input logic mr, input logic st, input logic fl);
    if (u == 0) begin
      s_val4 = sv; s_dat4 = sd; m_rdy4 = mr; stall4 = st; flush4 = fl;
      s_val3 = 1'b0; s_dat3 = '0; m_rdy3 = 1'b0; stall3 = 1'b0; flush3 = 1'b0;
    end else begin
      s_val3 = sv; s_dat3 = sd; m_rdy3 = mr; stall3 = st; flush3 = fl;
      s_val4 = 1'b0; s_dat4 = '0; m_rdy4 = 1'b0; stall4 = 1'b0; flush4 = 1'b0;
    end
  endtask

  // Predict this cycle from the scoreboard, compare on the falling edge,
  // then update the scoreboard to match what the rising edge will do.
  task automatic checkOutput(input int u, input string tag, input logic sv,
                             input logic [31:0] sd, input logic mr,
                             input logic st, input logic fl);
    int          depth;
    int          n;
    logic        exp_rdy;
    logic        exp_val;
    logic [31:0] exp_dat;
    logic [31:0] head;
    logic        o_rdy, o_val, o_busy, o_full;
    logic [31:0] o_dat;
    logic [2:0]  o_cnt;
    @(negedge clk);
    depth = (u == 0) ? 4 : 3;
    n     = (u == 0) ? sb4.size() : sb3.size();
    head  = '0;
    if (n > 0) head = (u == 0) ? sb4[0] : sb3[0];
    exp_rdy = (n < depth) && !st && !fl;
    exp_val = !st && !fl && ((n > 0) || (FT && sv));
    exp_dat = exp_val ? ((n > 0) ? head : sd) : 32'h0;
    if (u == 0) begin
      o_rdy = s_rdy4; o_val = m_val4; o_dat = m_dat4;
      o_busy = busy4; o_full = full4; o_cnt = cnt4;
    end else begin
      o_rdy = s_rdy3; o_val = m_val3; o_dat = m_dat3;
      o_busy = busy3; o_full = full3; o_cnt = {1'b0, cnt3};
    end
    chk({tag, ".ready"}, {31'd0, o_rdy},  {31'd0, exp_rdy});
    chk({tag, ".valid"}, {31'd0, o_val},  {31'd0, exp_val});
    chk({tag, ".data"},  o_dat,           exp_dat);
    chk({tag, ".busy"},  {31'd0, o_busy}, {31'd0, n > 0});
    chk({tag, ".full"},  {31'd0, o_full}, {31'd0, n == depth});
    chk({tag, ".count"}, {29'd0, o_cnt},  n);
    if (fl) begin
      if (u == 0) sb4.delete(); else sb3.delete();
    end else begin
      if (sv && exp_rdy) begin
        if (u == 0) sb4.push_back(sd); else sb3.push_back(sd);
      end
      if (exp_val && mr) begin
        if (u == 0) void'(sb4.pop_front()); else void'(sb3.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input int u, input string tag, input logic sv,
                       input logic [31:0] sd, input logic mr,
                       input logic st, input logic fl);
    applyStimulus(u, sv, sd, mr, st, fl);
    checkOutput(u, tag, sv, sd, mr, st, fl);
  endtask

  initial begin
    // Reset held with a payload offered: everything must stay quiet.
    rst = 1'b1;
    applyStimulus(0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    #2;
    chk("rst.ready", {31'd0, s_rdy4}, 32'd0);
    chk("rst.valid", {31'd0, m_val4}, 32'd0);
    chk("rst.data",  m_dat4,          32'd0);
    chk("rst.busy",  {31'd0, busy4},  32'd0);
    chk("rst.full",  {31'd0, full4},  32'd0);
    chk("rst.count", {29'd0, cnt4},   32'd0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill DEPTH=4 without draining, then try to push while full.
    for (int i = 0; i < 4; i++) cycle(0, "fill", 1'b1, 32'hA1 + i, 1'b0, 1'b0, 1'b0);
    cycle(0, "full_hold", 1'b1, 32'hEE, 1'b0, 1'b0, 1'b0);
    // Full with a pop in the same cycle: still no push accepted.
    cycle(0, "full_pop", 1'b1, 32'hEF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, "drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(0, "empty", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Push into empty buffer with consumer ready (bypass when fall-through).
    cycle(0, "lat_in",  1'b1, 32'h3C, 1'b1, 1'b0, 1'b0);
    cycle(0, "lat_out", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
    cycle(0, "lat_idle", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with two stored and a new payload offered.
    cycle(0, "fl_fill", 1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    cycle(0, "fl_fill", 1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
    cycle(0, "flush",   1'b1, 32'hB3, 1'b1, 1'b0, 1'b1);
    cycle(0, "fl_after", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Flush together with stall: flush still wins.
    cycle(0, "fl_fill2", 1'b1, 32'hB4, 1'b0, 1'b0, 1'b0);
    cycle(0, "fl_stall", 1'b1, 32'hB5, 1'b1, 1'b1, 1'b1);
    cycle(0, "fl_after2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Stall for three cycles with one stored, then release.
    cycle(0, "st_fill", 1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, "stall", 1'b1, 32'hC2, 1'b1, 1'b1, 1'b0);
    cycle(0, "st_rel",  1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(0, "st_idle", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges with three stored.
    for (int i = 0; i < 3; i++) cycle(0, "rs_fill", 1'b1, 32'hD1 + i, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.ready", {31'd0, s_rdy4}, 32'd0);
    chk("arst.valid", {31'd0, m_val4}, 32'd0);
    chk("arst.data",  m_dat4,          32'd0);
    chk("arst.busy",  {31'd0, busy4},  32'd0);
    chk("arst.full",  {31'd0, full4},  32'd0);
    chk("arst.count", {29'd0, cnt4},   32'd0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    sb4.delete();
    sb3.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, "post_rst_in",  1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    cycle(0, "post_rst_out", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0);

    // DEPTH=3: ten payloads streamed with push and pop every cycle.
    for (int i = 0; i < 10; i++) cycle(1, "wrap", 1'b1, 32'hE0 + i, 1'b1, 1'b0, 1'b0);
    cycle(1, "wrap_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1, "wrap_idle",  1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
